cannon_pe: RTL and testbench
============================

Name: cannon_pe

Overview:
- Parametrised processing element for a Cannon's-algorithm systolic matrix multiplier. One instance per grid cell (GRID x GRID array).
- Holds one A and one B operand and exposes them to its left/up neighbours each step.
- Accumulates GRID products under a start/stall/result valid-ready protocol, so the array controller can stall the mesh and drain results with backpressure.

Parameters:
- DATA_W, 8, operand width in bits.
- ACC_W, 24, accumulator/result width; must be >= 2*DATA_W (elaboration error otherwise).
- GRID, 4, number of MAC steps per tile (grid dimension); must be >= 1.
- SIGNED, 0, 1 = two's-complement operands and accumulator; 0 = unsigned.

Ports:
- clk  in  1  clock; all logic posedge.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse: load init operands, clear acc, begin tile; honoured only in IDLE.
- en  in  1  step enable; 0 stalls RUN (all state held).
- a_init  in  DATA_W  pre-skewed initial A operand.
- b_init  in  DATA_W  pre-skewed initial B operand.
- a_in  in  DATA_W  A from right neighbour's a_out.
- b_in  in  DATA_W  B from lower neighbour's b_out.
- a_out  out  DATA_W  current held A (a_reg).
- b_out  out  DATA_W  current held B (b_reg).
- busy  out  1  high in RUN.
- res_valid  out  1  high in DONE.
- res_ready  in  1  consumer accepts result.
- res  out  ACC_W  accumulated dot product; valid when res_valid.
- sat  out  1  sticky saturation flag for current tile; constant 0 without CANNON_SAT_EN.

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE; a_reg=b_reg=0, acc=0, cnt=0, sat=0. So a_out=b_out=res=0, busy=res_valid=0. Reset overrides everything, including mid-RUN and DONE; any partial tile is discarded.
- States IDLE, RUN, DONE.
- IDLE:
  - start=1: a_reg<=a_init, b_reg<=b_init, acc<=0, cnt<=0, sat<=0, ->RUN.
  - start=0: hold.
- RUN, en=1:
  - acc<=acc+ext(a_reg*b_reg); a_reg<=a_in; b_reg<=b_in; cnt<=cnt+1.
  - If cnt==GRID-1 -> DONE. The shift still occurs on the final step.
- RUN, en=0: all registers hold; no MAC, no shift.
- DONE: res_valid=1, res=acc, a_reg/b_reg hold.
  - res_ready=1: ->IDLE. acc is not cleared; res keeps its value until the next start.
- start outside IDLE is ignored (no restart, no error). start and res_ready in the same DONE cycle: only res_ready acts; start must be re-asserted in IDLE.
- MAC uses held operands (a_reg, b_reg), not a_in/b_in.
- Product is 2*DATA_W bits, sign- (SIGNED=1) or zero- (SIGNED=0) extended to ACC_W. Addition is modulo 2^ACC_W unless CANNON_SAT_EN is defined.
- Latency: start at edge 0 -> RUN from edge 1. With en held high, GRID MACs occur at edges 1..GRID and res_valid rises after edge GRID, i.e. GRID+1 cycles after start. Each en=0 cycle in RUN adds one cycle.
- GRID=1: exactly one MAC, then DONE.
- cnt width = $clog2(GRID+1).
- a_out/b_out are registered outputs; there is no combinational path from any input to any output.

Optional Feature:
- Macro CANNON_SAT_EN.
- Defined: accumulation clamps instead of wrapping.
  - SIGNED=1: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - SIGNED=0: clamp to 2^ACC_W-1.
  - sat<=1 on any clamp and stays set until the next start or rst.
- Not defined: wrap-around arithmetic; sat tied to 0; no saturation logic synthesised.

Decomposition:
- Shared package cannon_pkg:
  - state enum pe_state_t {IDLE, RUN, DONE};
  - function acc_ext() for width/sign extension;
  - localparam defaults DATA_W/ACC_W/GRID shared with the array top and controller.
- One sub-module, cannon_mac: combinational multiply + extend + add (+ saturate under CANNON_SAT_EN), parametrised by DATA_W, ACC_W, SIGNED. It outputs next_acc and a clamp flag. cannon_pe keeps the FSM, counter and operand registers.

Test Plan:
- Basic (DATA_W=8, ACC_W=24, GRID=4, SIGNED=0): a_init=3, b_init=5, a_in=2, b_in=7 constant, en=1, start pulse -> res_valid 5 cycles after start, res=15+14*3=57, a_out=2 after the first step, busy high for exactly 4 cycles.
- Stall: same stimulus with en=0 for 2 cycles mid-RUN -> res=57, res_valid 7 cycles after start, a_out/b_out frozen during the stall.
- Backpressure/restart: hold res_ready=0 for 3 cycles in DONE -> res_valid and res=57 stable. Assert start during DONE -> ignored. res_ready=1 -> IDLE next cycle. A new start with a_init=b_init=1, a_in=b_in=0 -> res=1.
- Signed with CANNON_SAT_EN (ACC_W=16, SIGNED=1): all operands -128 (0x80) -> 16384+16384=32768 clamps -> res=32767, sat=1 held until the next start. Same test without the macro -> res=0 (65536 mod 2^16), sat=0.
- Reset mid-operation: rst=1 on the 2nd RUN cycle -> next cycle state IDLE, res=0, a_out=b_out=0, busy=0, res_valid=0; a subsequent start yields a correct fresh result.
- GRID=1 and ignored start: GRID=1, a_init=9, b_init=9 -> res=81, res_valid 2 cycles after start. start pulsed while busy=1 in the GRID=4 configuration -> no effect on cnt or acc.

Source files
------------

// File: rtl/cannon_pkg.sv
// Shared types, defaults and the product extension helper for the Cannon PE array.
// Declarations only: no state, no latency, no flow control.
package cannon_pkg;

  localparam int DATA_W_DFLT = 8;
  localparam int ACC_W_DFLT  = 24;
  localparam int GRID_DFLT   = 4;
  localparam int EXT_W       = 64;

  typedef enum logic [1:0] {IDLE, RUN, DONE} pe_state_t;

  // Extend the low src_w bits of val to EXT_W bits, sign- or zero-filling above.
  function automatic logic [EXT_W-1:0] acc_ext(input logic [EXT_W-1:0] val,
                                               input int src_w,
                                               input logic is_signed);
    logic [EXT_W-1:0] r;
    logic msb;
    msb = 1'b0;
    for (int i = 0; i < EXT_W; i++)
      if (i == src_w - 1) msb = val[i];
    for (int i = 0; i < EXT_W; i++)
      r[i] = (i < src_w) ? val[i] : (is_signed & msb);
    return r;
  endfunction

endpackage

// File: rtl/cannon_mac.sv
// Combinational multiply-extend-accumulate; clamps instead of wrapping under CANNON_SAT_EN.
// Latency: 0 cycles (pure combinational). Backpressure: none, the caller decides when to commit.
module cannon_mac import cannon_pkg::*; #(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int ACC_W  = ACC_W_DFLT,
  parameter int SIGNED = 0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  next_acc,
  output logic              clamp
);

  localparam int   PROD_W = 2 * DATA_W;
  localparam logic SGN    = (SIGNED != 0);

  logic [PROD_W-1:0] a_x, b_x, prod;
  logic [EXT_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  addend;

  // Operands pre-extended to PROD_W so the low PROD_W bits are right for either signedness.
  assign a_x      = {{DATA_W{SGN & a[DATA_W-1]}}, a};
  assign b_x      = {{DATA_W{SGN & b[DATA_W-1]}}, b};
  assign prod     = a_x * b_x;
  assign prod_ext = acc_ext(EXT_W'(prod), PROD_W, SGN);
  assign addend   = prod_ext[ACC_W-1:0];

  if (ACC_W < EXT_W) begin : g_hi
    logic [EXT_W-ACC_W-1:0] unused_hi;
    assign unused_hi = prod_ext[EXT_W-1:ACC_W];
  end

`ifdef CANNON_SAT_EN
  logic [ACC_W:0] sum_x;

  always_comb begin
    sum_x    = {SGN & acc[ACC_W-1], acc} + {SGN & addend[ACC_W-1], addend};
    next_acc = sum_x[ACC_W-1:0];
    clamp    = 1'b0;
    if (SGN) begin
      if (sum_x[ACC_W] != sum_x[ACC_W-1]) begin
        clamp    = 1'b1;
        next_acc = sum_x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else if (sum_x[ACC_W]) begin
      clamp    = 1'b1;
      next_acc = '1;
    end
  end
`else
  assign next_acc = acc + addend;
  assign clamp    = 1'b0;
`endif

endmodule

// File: rtl/cannon_pe.sv
// Cannon systolic PE: holds A/B, shifts them left/up and accumulates GRID products (CANNON_SAT_EN: clamp).
// Latency: GRID+1 cycles start->res_valid with en high; each en=0 RUN cycle adds one.
// Backpressure: result held in DONE until res_ready; en=0 freezes the whole tile.
module cannon_pe import cannon_pkg::*; #(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int ACC_W  = ACC_W_DFLT,
  parameter int GRID   = GRID_DFLT,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  input  logic [DATA_W-1:0] a_init,
  input  logic [DATA_W-1:0] b_init,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res,
  output logic              sat
);

  localparam int             CNT_W = $clog2(GRID + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(GRID - 1);

  if (ACC_W < 2 * DATA_W) begin : g_chk_acc
    $error("cannon_pe: ACC_W must be >= 2*DATA_W");
  end
  if (ACC_W > EXT_W) begin : g_chk_ext
    $error("cannon_pe: ACC_W exceeds the package extension width");
  end
  if (GRID < 1) begin : g_chk_grid
    $error("cannon_pe: GRID must be >= 1");
  end

  pe_state_t         state_q, state_d;
  logic [DATA_W-1:0] a_reg, b_reg;
  logic [ACC_W-1:0]  acc_q, mac_acc;
  logic [CNT_W-1:0]  cnt_q;
  logic              load, step, mac_clamp;

  cannon_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_mac (
    .a        (a_reg),
    .b        (b_reg),
    .acc      (acc_q),
    .next_acc (mac_acc),
    .clamp    (mac_clamp)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        load    = 1'b1;
        state_d = RUN;
      end
      RUN: if (en) begin
        step = 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        a_reg <= a_init;
        b_reg <= b_init;
        acc_q <= '0;
        cnt_q <= '0;
      end else if (step) begin
        // The shift happens on every step, the last one included.
        a_reg <= a_in;
        b_reg <= b_in;
        acc_q <= mac_acc;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef CANNON_SAT_EN
  logic sat_q;
  always_ff @(posedge clk) begin
    if (rst || load)          sat_q <= 1'b0;
    else if (step && mac_clamp) sat_q <= 1'b1;
  end
  assign sat = sat_q;
`else
  logic unused_clamp;
  assign unused_clamp = mac_clamp;
  assign sat          = 1'b0;
`endif

  assign a_out     = a_reg;
  assign b_out     = b_reg;
  assign res       = acc_q;
  assign busy      = (state_q == RUN);
  assign res_valid = (state_q == DONE);

endmodule

// File: tb/tb_cannon_pe.sv
// Bench for cannon_pe: three instances (default, GRID=1, signed 16-bit acc) share one stimulus stream.
`timescale 1ns/1ps
module tb_cannon_pe;

`ifdef CANNON_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, en, res_ready;
  logic [7:0]  a_init, b_init, a_in, b_in;
  logic [7:0]  d_a_out, d_b_out, g_a_out, g_b_out, s_a_out, s_b_out;
  logic        d_busy, d_res_valid, d_sat, g_busy, g_res_valid, g_sat, s_busy, s_res_valid, s_sat;
  logic [23:0] d_res, g_res;
  logic [15:0] s_res;

  int total = 0;
  int bad   = 0;
  logic [7:0] qa[$], qb[$];
  int lat, busy_cycles, nstall;

  always #5 clk = ~clk;

  cannon_pe u_dut (
    .clk(clk), .rst(rst), .start(start), .en(en), .a_init(a_init), .b_init(b_init),
    .a_in(a_in), .b_in(b_in), .a_out(d_a_out), .b_out(d_b_out), .busy(d_busy),
    .res_valid(d_res_valid), .res_ready(res_ready), .res(d_res), .sat(d_sat));

  cannon_pe #(.GRID(1)) u_g1 (
    .clk(clk), .rst(rst), .start(start), .en(en), .a_init(a_init), .b_init(b_init),
    .a_in(a_in), .b_in(b_in), .a_out(g_a_out), .b_out(g_b_out), .busy(g_busy),
    .res_valid(g_res_valid), .res_ready(res_ready), .res(g_res), .sat(g_sat));

  cannon_pe #(.ACC_W(16), .SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst), .start(start), .en(en), .a_init(a_init), .b_init(b_init),
    .a_in(a_in), .b_in(b_in), .a_out(s_a_out), .b_out(s_b_out), .busy(s_busy),
    .res_valid(s_res_valid), .res_ready(res_ready), .res(s_res), .sat(s_sat));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; en = 1'b0; res_ready = 1'b0;
    a_init = '0; b_init = '0; a_in = '0; b_in = '0;
    tick; tick;
    rst = 1'b0;
  endtask

  function automatic logic [7:0] rnd8;
    case ($urandom_range(3))
      0: return 8'h80;
      1: return 8'h7f;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic fill_random(input int n);
    qa.delete(); qb.delete();
    for (int i = 0; i < n; i++) begin
      qa.push_back(rnd8());
      qb.push_back(rnd8());
    end
  endtask

  // Dot product of the operand sequence, one clamp or wrap per step.
  function automatic longint model(input int grid, input int acc_w, input bit sgn, output bit clamped);
    longint acc, p, m, lo, hi;
    m = longint'(1) << acc_w;
    lo = sgn ? -(m / 2) : 0;
    hi = sgn ? (m / 2 - 1) : (m - 1);
    acc = 0;
    clamped = 1'b0;
    for (int k = 0; k < grid; k++) begin
      if (sgn) p = longint'($signed(qa[k])) * longint'($signed(qb[k]));
      else     p = longint'(qa[k]) * longint'(qb[k]);
      acc = acc + p;
      if (SAT_EN) begin
        if (acc > hi) begin acc = hi; clamped = 1'b1; end
        else if (acc < lo) begin acc = lo; clamped = 1'b1; end
      end else begin
        acc = ((acc % m) + m) % m;
      end
    end
    return ((acc % m) + m) % m;
  endfunction

  // Operand k of the tile is qa[k]; qa[k+1] is presented on a_in while step k is pending.
  task automatic run_tile(input int grid, input int stall_pct, input logic [31:0] stall_mask, input bit noisy);
    int step, cyc;
    logic v, bz;
    logic [7:0] ao, bo;
    a_init = qa[0]; b_init = qb[0]; start = 1'b1; en = 1'b1; res_ready = 1'b0;
    tick;
    start = 1'b0; step = 0; cyc = 1; busy_cycles = 0; nstall = 0; lat = -1;
    while (cyc < 300) begin
      v  = (grid == 1) ? g_res_valid : d_res_valid;
      bz = (grid == 1) ? g_busy : d_busy;
      ao = (grid == 1) ? g_a_out : d_a_out;
      bo = (grid == 1) ? g_b_out : d_b_out;
      total++;
      if (ao !== qa[step] || bo !== qb[step]) begin
        bad++;
        $display("FAIL operand_out cyc=%0d step=%0d got a=%0d b=%0d want a=%0d b=%0d",
                 cyc, step, ao, bo, qa[step], qb[step]);
      end
      if (v) begin
        lat = cyc;
        break;
      end
      if (bz) busy_cycles++;
      en = !(cyc < 32 && stall_mask[cyc[4:0]]) && ($urandom_range(99) >= stall_pct);
      if (!en) nstall++;
      a_in = (step + 1 < qa.size()) ? qa[step + 1] : 8'($urandom);
      b_in = (step + 1 < qb.size()) ? qb[step + 1] : 8'($urandom);
      start = noisy && ($urandom_range(2) == 0);
      if (start) begin
        a_init = 8'($urandom);
        b_init = 8'($urandom);
      end
      tick;
      if (en) step++;
      cyc++;
    end
    start = 1'b0; en = 1'b0;
    total++;
    if (lat < 0) begin
      bad++;
      $display("FAIL tile_timeout got no res_valid within %0d cycles want grid=%0d", cyc, grid);
    end
  endtask

  task automatic accept;
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    total++;
    if ({d_a_out, d_b_out, d_res, d_busy, d_res_valid, d_sat} !== '0) begin
      bad++;
      $display("FAIL reset_state got a=%0d b=%0d res=%0d busy=%b vld=%b sat=%b want all 0",
               d_a_out, d_b_out, d_res, d_busy, d_res_valid, d_sat);
    end
  endtask

  task automatic test_basic;
    do_reset;
    qa = '{8'd3, 8'd2, 8'd2, 8'd2, 8'd2};
    qb = '{8'd5, 8'd7, 8'd7, 8'd7, 8'd7};
    run_tile(4, 0, 32'h0, 1'b0);
    total++;
    if (d_res !== 24'd57) begin bad++; $display("FAIL basic_res got %0d want 57", d_res); end
    total++;
    if (lat != 5) begin bad++; $display("FAIL basic_latency got %0d want 5", lat); end
    total++;
    if (busy_cycles != 4) begin bad++; $display("FAIL basic_busy got %0d want 4", busy_cycles); end
    accept;
    total++;
    if (d_busy !== 1'b0 || d_res_valid !== 1'b0 || d_res !== 24'd57) begin
      bad++;
      $display("FAIL basic_accept got busy=%b vld=%b res=%0d want 0 0 57", d_busy, d_res_valid, d_res);
    end
  endtask

  task automatic test_stall;
    do_reset;
    qa = '{8'd3, 8'd2, 8'd2, 8'd2, 8'd2};
    qb = '{8'd5, 8'd7, 8'd7, 8'd7, 8'd7};
    run_tile(4, 0, 32'h0000_000c, 1'b0);
    total++;
    if (d_res !== 24'd57) begin bad++; $display("FAIL stall_res got %0d want 57", d_res); end
    total++;
    if (lat != 7) begin bad++; $display("FAIL stall_latency got %0d want 7", lat); end
    total++;
    if (busy_cycles != 6) begin bad++; $display("FAIL stall_busy got %0d want 6", busy_cycles); end
  endtask

  task automatic test_backpressure;
    do_reset;
    qa = '{8'd3, 8'd2, 8'd2, 8'd2, 8'd2};
    qb = '{8'd5, 8'd7, 8'd7, 8'd7, 8'd7};
    run_tile(4, 0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if (d_res_valid !== 1'b1 || d_res !== 24'd57) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got vld=%b res=%0d want 1 57", i, d_res_valid, d_res);
      end
    end
    a_init = 8'd99; b_init = 8'd99; start = 1'b1;
    tick;
    start = 1'b0;
    total++;
    if (d_res_valid !== 1'b1 || d_res !== 24'd57 || d_a_out !== 8'd2) begin
      bad++;
      $display("FAIL bp_start_in_done got vld=%b res=%0d a=%0d want 1 57 2", d_res_valid, d_res, d_a_out);
    end
    start = 1'b1; res_ready = 1'b1;
    tick;
    start = 1'b0; res_ready = 1'b0;
    tick;
    total++;
    if (d_busy !== 1'b0 || d_res_valid !== 1'b0 || d_res !== 24'd57) begin
      bad++;
      $display("FAIL bp_start_with_ready got busy=%b vld=%b res=%0d want 0 0 57", d_busy, d_res_valid, d_res);
    end
    qa = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    qb = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    run_tile(4, 0, 32'h0, 1'b0);
    total++;
    if (d_res !== 24'd1) begin bad++; $display("FAIL bp_restart_res got %0d want 1", d_res); end
    accept;
  endtask

  task automatic test_signed;
    bit cl;
    longint e;
    logic [15:0] want;
    do_reset;
    qa = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    qb = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    run_tile(4, 0, 32'h0, 1'b0);
    want = SAT_EN ? 16'h7fff : 16'h0000;
    total++;
    if (s_res !== want || s_sat !== SAT_EN) begin
      bad++;
      $display("FAIL signed_extreme got res=%0d sat=%b want res=%0d sat=%b", s_res, s_sat, want, SAT_EN);
    end
    accept;
    tick;
    total++;
    if (s_sat !== SAT_EN) begin bad++; $display("FAIL signed_sat_sticky got %b want %b", s_sat, SAT_EN); end
    qa = '{8'd2, 8'hfe, 8'd3, 8'd1, 8'd0};
    qb = '{8'd5, 8'd4, 8'hfd, 8'd1, 8'd0};
    run_tile(4, 0, 32'h0, 1'b0);
    e = model(4, 16, 1'b1, cl);
    total++;
    if (s_res !== 16'(e) || s_sat !== cl) begin
      bad++;
      $display("FAIL signed_small got res=%0d sat=%b want res=%0d sat=%b", s_res, s_sat, 16'(e), cl);
    end
    accept;
  endtask

  task automatic test_reset_mid;
    bit cl;
    longint e;
    do_reset;
    fill_random(5);
    a_init = qa[0]; b_init = qb[0]; start = 1'b1;
    tick;
    start = 1'b0; en = 1'b1; a_in = qa[1]; b_in = qb[1];
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0; en = 1'b0;
    total++;
    if ({d_a_out, d_b_out, d_res, d_busy, d_res_valid, d_sat} !== '0) begin
      bad++;
      $display("FAIL reset_mid got a=%0d b=%0d res=%0d busy=%b vld=%b want all 0",
               d_a_out, d_b_out, d_res, d_busy, d_res_valid);
    end
    fill_random(5);
    run_tile(4, 0, 32'h0, 1'b0);
    e = model(4, 24, 1'b0, cl);
    total++;
    if (d_res !== 24'(e)) begin bad++; $display("FAIL reset_mid_fresh got %0d want %0d", d_res, 24'(e)); end
    accept;
  endtask

  task automatic test_grid1;
    do_reset;
    qa = '{8'd9, 8'd4};
    qb = '{8'd9, 8'd6};
    run_tile(1, 0, 32'h0, 1'b0);
    total++;
    if (g_res !== 24'd81) begin bad++; $display("FAIL grid1_res got %0d want 81", g_res); end
    total++;
    if (lat != 2) begin bad++; $display("FAIL grid1_latency got %0d want 2", lat); end
    accept;
  endtask

  task automatic test_ignored_start;
    bit cl;
    longint e;
    do_reset;
    fill_random(5);
    run_tile(4, 0, 32'h0, 1'b1);
    e = model(4, 24, 1'b0, cl);
    total++;
    if (d_res !== 24'(e) || lat != 5) begin
      bad++;
      $display("FAIL ignored_start got res=%0d lat=%0d want res=%0d lat=5", d_res, lat, 24'(e));
    end
    accept;
  endtask

  task automatic test_random;
    bit cl_u, cl_s;
    longint eu, es;
    do_reset;
    for (int t = 0; t < 20; t++) begin
      fill_random(5);
      run_tile(4, 30, 32'h0, 1'b1);
      eu = model(4, 24, 1'b0, cl_u);
      es = model(4, 16, 1'b1, cl_s);
      total++;
      if (d_res !== 24'(eu)) begin bad++; $display("FAIL rand_unsigned t=%0d got %0d want %0d", t, d_res, 24'(eu)); end
      total++;
      if (s_res !== 16'(es) || s_sat !== cl_s) begin
        bad++;
        $display("FAIL rand_signed t=%0d got res=%0d sat=%b want res=%0d sat=%b", t, s_res, s_sat, 16'(es), cl_s);
      end
      total++;
      if (lat != 5 + nstall || busy_cycles != 4 + nstall) begin
        bad++;
        $display("FAIL rand_timing t=%0d got lat=%0d busy=%0d want lat=%0d busy=%0d",
                 t, lat, busy_cycles, 5 + nstall, 4 + nstall);
      end
      accept;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_backpressure;
    test_signed;
    test_reset_mid;
    test_grid1;
    test_ignored_start;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
